// File: rtl/gbe_rxpacketstore_if.sv
// Signal bundle between the MAC receiver / packet consumer (master) and the
// receive packet store (slave).
interface gbe_rxpacketstore_if #(
  parameter int LEN_W = 11
);
  logic [7:0]       mac_rxd;
  logic             mac_rxdv;
  logic             mac_rxpacketok;
  logic             mac_rxpacketbad;
  logic [LEN_W-1:0] packet_rxa;
  logic [7:0]       packet_rxd;
  logic [LEN_W-1:0] packet_len;
  logic             packet_rxready;
  logic             packet_rxdone;

  modport master (
    output mac_rxd, mac_rxdv, mac_rxpacketok, mac_rxpacketbad, packet_rxa, packet_rxdone,
    input  packet_rxd, packet_len, packet_rxready
  );

  modport slave (
    input  mac_rxd, mac_rxdv, mac_rxpacketok, mac_rxpacketbad, packet_rxa, packet_rxdone,
    output packet_rxd, packet_len, packet_rxready
  );
endinterface

// File: rtl/gbe_rxpacketstore.sv
// Receive packet store: good frames are committed into a circular byte RAM with
// a length queue; overflowing, oversize, empty and bad frames are dropped and counted.
module gbe_rxpacketstore #(
  parameter int ADDR_W  = 12,
  parameter int LENQ_W  = 3,
  parameter int LEN_W   = 11,
  parameter int MAX_LEN = 1536,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  gbe_rxpacketstore_if.slave  bus,
  output logic [CNT_W-1:0]    cnt_accepted,
  output logic [CNT_W-1:0]    cnt_drop_bad,
  output logic [CNT_W-1:0]    cnt_drop_full,
  output logic [CNT_W-1:0]    cnt_drop_len
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int QDEPTH = 1 << LENQ_W;

  typedef enum logic {RECV, DROP} state_t;

  state_t            state_q, state_d;
  logic              drop_len_q, drop_len_d;
  logic [LEN_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W:0]   used_q, used_d;
  logic [LENQ_W:0]   wr_ptr_q, wr_ptr_d;
  logic [LENQ_W:0]   rd_ptr_q, rd_ptr_d;
  logic              rxdone_q, rxdone_d;
  logic              ready_q, ready_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        rxd_q;
  logic [CNT_W-1:0]  cnt_accepted_q, cnt_accepted_d;
  logic [CNT_W-1:0]  cnt_drop_bad_q, cnt_drop_bad_d;
  logic [CNT_W-1:0]  cnt_drop_full_q, cnt_drop_full_d;
  logic [CNT_W-1:0]  cnt_drop_len_q, cnt_drop_len_d;

  logic [7:0]        ram  [DEPTH];
  logic [LEN_W-1:0]  lenq [QDEPTH];

  logic [ADDR_W:0]   free;
  logic              at_max, at_free, byte_drop, byte_wr;
  logic [LEN_W-1:0]  acc_next, head_len;
  logic              in_drop, cause_len;
  logic              q_empty, q_full;
  logic              end_ok, end_bad, commit, pop;
  logic              inc_len, inc_full;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    free      = (ADDR_W+1)'(DEPTH) - used_q;
    at_max    = (acc_q == LEN_W'(MAX_LEN));
    at_free   = ((ADDR_W+1)'(acc_q) == free);
    byte_drop = bus.mac_rxdv && (state_q == RECV) && (at_max || at_free);
    byte_wr   = bus.mac_rxdv && (state_q == RECV) && !byte_drop;
    acc_next  = acc_q + LEN_W'(byte_wr);
    wr_addr   = wr_base_q + ADDR_W'(acc_q);
    rd_addr   = rd_base_q + ADDR_W'(bus.packet_rxa);

    // A byte arriving with the end pulse is judged first, so its drop decides the outcome.
    in_drop   = (state_q == DROP) || byte_drop;
    cause_len = (state_q == DROP) ? drop_len_q : at_max;

    q_empty   = (wr_ptr_q == rd_ptr_q);
    q_full    = (wr_ptr_q[LENQ_W] != rd_ptr_q[LENQ_W]) &&
                (wr_ptr_q[LENQ_W-1:0] == rd_ptr_q[LENQ_W-1:0]);
    head_len  = lenq[rd_ptr_q[LENQ_W-1:0]];

    end_bad   = bus.mac_rxpacketbad;
    end_ok    = bus.mac_rxpacketok && !bus.mac_rxpacketbad;
    commit    = end_ok && !in_drop && (acc_next != '0) && !q_full;
    inc_len   = end_ok && (in_drop ? cause_len : (acc_next == '0));
    inc_full  = end_ok && (in_drop ? !cause_len : ((acc_next != '0) && q_full));
    pop       = bus.packet_rxdone && !rxdone_q && ready_q && !q_empty;

    state_d    = state_q;
    drop_len_d = drop_len_q;
    if (byte_drop) begin
      state_d    = DROP;
      drop_len_d = at_max;
    end
    if (bus.mac_rxpacketok || bus.mac_rxpacketbad) begin
      state_d = RECV;
      acc_d   = '0;
    end else begin
      acc_d   = acc_next;
    end

    // Commit and release can land in the same cycle; used takes the net change.
    used_d    = used_q + (commit ? (ADDR_W+1)'(acc_next) : '0)
                       - (pop ? (ADDR_W+1)'(head_len) : '0);
    wr_base_d = commit ? wr_base_q + ADDR_W'(acc_next) : wr_base_q;
    rd_base_d = pop ? rd_base_q + ADDR_W'(head_len) : rd_base_q;
    wr_ptr_d  = wr_ptr_q + (LENQ_W+1)'(commit);
    rd_ptr_d  = rd_ptr_q + (LENQ_W+1)'(pop);
    rxdone_d  = bus.packet_rxdone;

    ready_d   = !q_empty;
    len_d     = q_empty ? '0 : head_len;

    cnt_accepted_d  = sat_inc(cnt_accepted_q, commit);
    cnt_drop_bad_d  = sat_inc(cnt_drop_bad_q, end_bad);
    cnt_drop_full_d = sat_inc(cnt_drop_full_q, inc_full);
    cnt_drop_len_d  = sat_inc(cnt_drop_len_q, inc_len);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= RECV;
      drop_len_q      <= 1'b0;
      acc_q           <= '0;
      wr_base_q       <= '0;
      rd_base_q       <= '0;
      used_q          <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      rxdone_q        <= 1'b0;
      ready_q         <= 1'b0;
      len_q           <= '0;
      cnt_accepted_q  <= '0;
      cnt_drop_bad_q  <= '0;
      cnt_drop_full_q <= '0;
      cnt_drop_len_q  <= '0;
    end else begin
      state_q         <= state_d;
      drop_len_q      <= drop_len_d;
      acc_q           <= acc_d;
      wr_base_q       <= wr_base_d;
      rd_base_q       <= rd_base_d;
      used_q          <= used_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      rxdone_q        <= rxdone_d;
      ready_q         <= ready_d;
      len_q           <= len_d;
      cnt_accepted_q  <= cnt_accepted_d;
      cnt_drop_bad_q  <= cnt_drop_bad_d;
      cnt_drop_full_q <= cnt_drop_full_d;
      cnt_drop_len_q  <= cnt_drop_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && byte_wr) ram[wr_addr] <= bus.mac_rxd;
    if (reset_n && commit) lenq[wr_ptr_q[LENQ_W-1:0]] <= acc_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rxd_q <= '0;
    else          rxd_q <= ram[rd_addr];
  end

  assign bus.packet_rxd     = rxd_q;
  assign bus.packet_len     = len_q;
  assign bus.packet_rxready = ready_q;
  assign cnt_accepted       = cnt_accepted_q;
  assign cnt_drop_bad       = cnt_drop_bad_q;
  assign cnt_drop_full      = cnt_drop_full_q;
  assign cnt_drop_len       = cnt_drop_len_q;
endmodule

// File: doc/gbe_rxpacketstore.md
# gbe_rxpacketstore

Single-clock, parametrised receive packet store for the GbE/IPbus datapath: accepts MAC receive bytes, commits good frames into a circular byte RAM with a length queue, and presents whole frames to the packet consumer by random-access address. It generalises buffer depth, queue depth and maximum frame length. Unlike the previous generation, it checks free space and queue occupancy, drops frames that would overflow, oversize or empty frames, and exports drop/accept statistics.

## Interface
- ADDR_W, 12: byte RAM depth = 2^ADDR_W bytes.
- LENQ_W, 3: length queue depth = 2^LENQ_W frames.
- LEN_W, 11: width of frame length and read offset; LEN_W <= ADDR_W.
- MAX_LEN, 1536: largest committable frame in bytes; MAX_LEN < 2^LEN_W and MAX_LEN <= 2^ADDR_W.
- CNT_W, 16: statistics counter width.
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- mac_rxd  in  8  receive byte, valid when mac_rxdv=1.
- mac_rxdv  in  1  byte strobe.
- mac_rxpacketok  in  1  one-cycle end-of-frame pulse, frame good.
- mac_rxpacketbad  in  1  one-cycle end-of-frame pulse, frame bad.
- packet_rxa  in  LEN_W  byte offset into head frame.
- packet_rxd  out  8  byte at head base + packet_rxa, one cycle after address.
- packet_len  out  LEN_W  head frame length, valid while packet_rxready=1.
- packet_rxready  out  1  at least one committed frame queued.
- packet_rxdone  in  1  consumer finished head frame; rising edge releases it.
- cnt_accepted  out  CNT_W  frames committed.
- cnt_drop_bad  out  CNT_W  frames ended by mac_rxpacketbad.
- cnt_drop_full  out  CNT_W  frames dropped for RAM space or queue full.
- cnt_drop_len  out  CNT_W  frames dropped for length 0 or > MAX_LEN.

## Operation
- Write FSM states: RECV (accumulating) and DROP (discarding until end pulse). Reset state is RECV, acc=0.
- RECV, mac_rxdv=1: if acc == MAX_LEN or acc == free, go to DROP and write nothing. free = 2^ADDR_W - used. Otherwise write mac_rxd at (wr_base + acc) mod 2^ADDR_W, then acc+1.
- End pulse: if mac_rxpacketok and mac_rxpacketbad are both high, bad wins. A byte strobed in the same cycle as an end pulse belongs to that frame and is evaluated first.
- On ok in RECV, the frame is committed if acc>0 and the queue is not full. Commit pushes acc to the queue, sets wr_base += acc and used += acc, and increments cnt_accepted.
- On ok in RECV, acc==0 increments cnt_drop_len. A full queue increments cnt_drop_full. In both cases nothing is committed.
- On ok in DROP: cnt_drop_len if the drop cause was MAX_LEN, else cnt_drop_full.
- On bad in either state: cnt_drop_bad.
- Every end pulse sets acc to 0 and returns the FSM to RECV.
- Dropped bytes may have been written past wr_base. They are never committed, and later frames overwrite them.
- Read side: head base rd_base. The RAM read address is (rd_base + packet_rxa) mod 2^ADDR_W. packet_rxa beyond packet_len returns undefined data and has no side effects.
- Release: a rising edge of packet_rxdone with packet_rxready=1 pops the queue, sets rd_base += packet_len and used -= packet_len. A rising edge while empty is ignored.
- used is updated once per cycle with the net of commit and release, so a simultaneous commit and release are both honoured.
- Counters saturate at 2^CNT_W-1.
- Address arithmetic wraps modulo 2^ADDR_W; queue pointers wrap modulo 2^LENQ_W, with an extra bit for full/empty.

## Timing
- Reset (reset_n=0 at a clk edge) clears wr_base, rd_base, used, acc, queue pointers, counters and the rxdone edge register, and sets the FSM to RECV. The frame in progress is lost.
- Output reset values: packet_rxready=0, packet_len=0, packet_rxd=0, all counters 0.
- Byte strobed at edge N is readable by address from edge N+1, once committed.
- Commit: ok at edge N gives packet_rxready=1 and a valid packet_len after edge N+1.
- Read latency: packet_rxa presented before edge N gives packet_rxd after edge N (registered RAM output).
- Release: rxdone rise sampled at edge N. packet_len/packet_rxready reflect the next head after edge N+1. The consumer holds packet_rxdone high until packet_rxready or packet_len changes.
- Free space freed by a release is usable by a byte strobed after the release edge.

## Test plan
- Single frame of 64 bytes 0x00..0x3F followed by ok: packet_rxready=1 two edges after ok, packet_len=64. Reading offsets 0..63 returns 0x00..0x3F. rxdone rise gives packet_rxready=0, cnt_accepted=1.
- 9 back-to-back 60-byte frames with no reads (LENQ_W=3): 8 committed, 9th gives cnt_drop_full=1. Release all 8: each length is 60, with correct data.
- Frame of 1537 bytes then ok: cnt_drop_len=1, nothing queued. A following 100-byte frame commits and reads correctly.
- Frame ended by ok and bad together: cnt_drop_bad=1, not queued. A zero-length ok gives cnt_drop_len=1.
- ADDR_W=12, frames of 1500 bytes with delayed reads: 3rd frame overflows (cnt_drop_full=1). After two releases, a frame straddling address 4095->0 reads back intact.
- reset_n low mid-frame and with 2 frames queued: all outputs 0 next edge, and the next frame commits at base 0.
